// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry block: FSM states,
// special key indices, key-to-digit map and small decode helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    localparam int unsigned ENTRY_W = 19;
    localparam int unsigned MAG_W   = 10;

    localparam logic [3:0] KEY_A    = 4'd3;
    localparam logic [3:0] KEY_STAR = 4'd12;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] NO_DIGIT = 4'hF;

    // Key index (row*4+col) to decimal digit; NO_DIGIT marks letters, '*' and '#'.
    localparam logic [15:0][3:0] KEY_DIGIT = {
        4'hF, 4'hF, 4'h0, 4'hF,   // 15..12 : D # 0 *
        4'hF, 4'h9, 4'h8, 4'h7,   // 11..8  : C 9 8 7
        4'hF, 4'h6, 4'h5, 4'h4,   //  7..4  : B 6 5 4
        4'hF, 4'h3, 4'h2, 4'h1    //  3..0  : A 3 2 1
    };

    // Index of the driven (low) row.
    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        logic [1:0] idx;
        case (row_n)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    // Lowest-index low column wins when several are pressed.
    function automatic logic [1:0] first_low_col(input logic [3:0] col_n);
        logic [1:0] idx;
        if (!col_n[0])      idx = 2'd0;
        else if (!col_n[1]) idx = 2'd1;
        else if (!col_n[2]) idx = 2'd2;
        else                idx = 2'd3;
        return idx;
    endfunction

    // Two's-complement view of a sign/magnitude entry; -0 yields 0.
    function automatic logic [ENTRY_W-1:0] signed_entry(input logic neg,
                                                         input logic [MAG_W-1:0] mag);
        logic [ENTRY_W-1:0] ext;
        ext = ENTRY_W'(mag);
        return neg ? (ENTRY_W'(0) - ext) : ext;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row scanner and press/release debouncer for a 4x4 active-low keypad.
// Emits a registered strobe/code pair plus their next-cycle values so the
// datapath can act on a key in the same cycle the strobe appears.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_BIT        = 17,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk1,
    input  logic       reset1,
    input  logic [3:0] col_n_i,
    output logic [3:0] row_n_o,
    output logic       key_strobe_o,
    output logic [3:0] key_code_o,
    output logic       key_strobe_c_o,
    output logic [3:0] key_code_c_o
);

    localparam int unsigned SCAN_W = SCAN_BIT + 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    state_e            state_q, state_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [3:0]        row_n_q, row_n_d;
    logic [3:0]        snap_q, snap_d;
    logic              strobe_q, strobe_d;
    logic [3:0]        code_q, code_d;

    // State and datapath registers.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state_q    <= SCAN;
            scan_cnt_q <= '0;
            db_cnt_q   <= '0;
            row_n_q    <= 4'b1110;
            snap_q     <= 4'hF;
            strobe_q   <= 1'b0;
            code_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            scan_cnt_q <= scan_cnt_d;
            db_cnt_q   <= db_cnt_d;
            row_n_q    <= row_n_d;
            snap_q     <= snap_d;
            strobe_q   <= strobe_d;
            code_q     <= code_d;
        end
    end

    // Next-state: scan rows, debounce press, hold, debounce release.
    always_comb begin
        state_d    = state_q;
        scan_cnt_d = scan_cnt_q;
        db_cnt_d   = db_cnt_q;
        row_n_d    = row_n_q;
        snap_d     = snap_q;
        strobe_d   = 1'b0;
        code_d     = code_q;

        case (state_q)
            SCAN: begin
                if (col_n_i != 4'hF) begin
                    snap_d   = col_n_i;
                    db_cnt_d = '0;
                    state_d  = PRESS_DB;
                end else begin
                    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                    if (scan_cnt_d[SCAN_BIT] != scan_cnt_q[SCAN_BIT]) begin
                        row_n_d = {row_n_q[2:0], row_n_q[3]};
                    end
                end
            end
            PRESS_DB: begin
                if (col_n_i != snap_q) begin
                    db_cnt_d = '0;
                    state_d  = SCAN;
                end else if (db_cnt_q == DB_LAST) begin
                    db_cnt_d = '0;
                    state_d  = HELD;
                    strobe_d = 1'b1;
                    code_d   = {row_index(row_n_q), first_low_col(snap_q)};
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            HELD: begin
                if (col_n_i == 4'hF) begin
                    db_cnt_d = '0;
                    state_d  = REL_DB;
                end
            end
            REL_DB: begin
                if (col_n_i != 4'hF) begin
                    db_cnt_d = '0;
                    state_d  = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    db_cnt_d   = '0;
                    scan_cnt_d = '0;
                    row_n_d    = {row_n_q[2:0], row_n_q[3]};
                    state_d    = SCAN;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign row_n_o        = row_n_q;
    assign key_strobe_o   = strobe_q;
    assign key_code_o     = code_q;
    assign key_strobe_c_o = strobe_d;
    assign key_code_c_o   = code_d;

endmodule

// File: rtl/keypad_entry.sv
// Keypad number entry: builds a signed decimal of up to MAX_DIGITS digits
// and commits it on '#'. Define KEYPAD_NEG_EN to let key A toggle the sign;
// otherwise entries are always non-negative.
module keypad_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_BIT        = 17,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned MAX_DIGITS      = 3
) (
    input  logic         clk1,
    input  logic         reset1,
    output logic [3:0]   row_n,
    input  logic [3:0]   col_n,
    output logic [18:0]  entry_val,
    output logic [18:0]  value,
    output logic         value_valid,
    output logic         key_strobe,
    output logic [3:0]   key_code,
    output logic [1:0]   digit_count
);

    logic             strobe_c;
    logic [3:0]       code_c;
    logic [3:0]       digit_c;

    logic [MAG_W-1:0]   mag_q, mag_d;
    logic [1:0]         digits_q, digits_d;
    logic               sign_q, sign_d;
    logic [ENTRY_W-1:0] entry_q, entry_d;
    logic [ENTRY_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;

    keypad_scan #(
        .SCAN_BIT        (SCAN_BIT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_scan (
        .clk1           (clk1),
        .reset1         (reset1),
        .col_n_i        (col_n),
        .row_n_o        (row_n),
        .key_strobe_o   (key_strobe),
        .key_code_o     (key_code),
        .key_strobe_c_o (strobe_c),
        .key_code_c_o   (code_c)
    );

    assign digit_c = KEY_DIGIT[code_c];

    // Entry, sign and commit registers.
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            mag_q    <= '0;
            digits_q <= '0;
            sign_q   <= 1'b0;
            entry_q  <= '0;
            value_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mag_q    <= mag_d;
            digits_q <= digits_d;
            sign_q   <= sign_d;
            entry_q  <= entry_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
        end
    end

    // Apply the key arriving with next cycle's strobe.
    always_comb begin
        mag_d    = mag_q;
        digits_d = digits_q;
        sign_d   = sign_q;
        value_d  = value_q;
        valid_d  = 1'b0;

        if (strobe_c) begin
            if (digit_c != NO_DIGIT) begin
                if (digits_q < 2'(MAX_DIGITS)) begin
                    mag_d    = (mag_q * MAG_W'(10)) + MAG_W'(digit_c);
                    digits_d = digits_q + 2'd1;
                end
            end else if (code_c == KEY_STAR) begin
                mag_d    = '0;
                digits_d = '0;
                sign_d   = 1'b0;
            end else if (code_c == KEY_HASH) begin
                value_d  = signed_entry(sign_q, mag_q);
                valid_d  = 1'b1;
                mag_d    = '0;
                digits_d = '0;
                sign_d   = 1'b0;
            end
`ifdef KEYPAD_NEG_EN
            else if (code_c == KEY_A) begin
                sign_d = ~sign_q;
            end
`endif
        end

        entry_d = signed_entry(sign_d, mag_d);
    end

    assign entry_val   = entry_q;
    assign value       = value_q;
    assign value_valid = valid_q;
    assign digit_count = digits_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural 4x4 key matrix.
module tb_keypad_entry;

    logic        clk1;
    logic        reset1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [18:0] entry_val;
    logic [18:0] value;
    logic        value_valid;
    logic        key_strobe;
    logic [3:0]  key_code;
    logic [1:0]  digit_count;

    logic        key_down;
    logic [1:0]  key_row;
    logic [3:0]  key_mask;

    int n_checks;
    int n_fails;
    int strobe_cnt;
    int valid_cnt;

    logic [3:0] rows [4];

    keypad_entry #(
        .SCAN_BIT        (2),
        .DEBOUNCE_CYCLES (4),
        .MAX_DIGITS      (3)
    ) dut (
        .clk1        (clk1),
        .reset1      (reset1),
        .row_n       (row_n),
        .col_n       (col_n),
        .entry_val   (entry_val),
        .value       (value),
        .value_valid (value_valid),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .digit_count (digit_count)
    );

    // Matrix model: pressed columns pull low only while their row is driven.
    assign col_n = (key_down && (row_n[key_row] == 1'b0)) ? ~key_mask : 4'hF;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    always @(posedge clk1) begin
        if (key_strobe === 1'b1)  strobe_cnt <= strobe_cnt + 1;
        if (value_valid === 1'b1) valid_cnt  <= valid_cnt + 1;
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Press, wait (bounded) for the strobe, hold briefly, release and settle.
    task automatic press_key(input string tag, input logic [1:0] r, input logic [3:0] m);
        bit seen;
        key_row  = r;
        key_mask = m;
        key_down = 1'b1;
        seen     = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            tick();
            if (key_strobe === 1'b1) seen = 1'b1;
        end
        check({tag, "_strobe_seen"}, 32'(seen), 32'd1);
        repeat (3) tick();
        key_down = 1'b0;
        repeat (12) tick();
    endtask

    task automatic wait_row(input logic [3:0] target, input bit equal);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 32 && !ok; n++) begin
            tick();
            if ((row_n == target) == equal) ok = 1'b1;
        end
        check("wait_row", 32'(ok), 32'd1);
    endtask

    initial begin
        int s0;
        int v0;
        int n_seen;
        bit seen;

        rows[0] = 4'b1110;
        rows[1] = 4'b1101;
        rows[2] = 4'b1011;
        rows[3] = 4'b0111;
        n_checks   = 0;
        n_fails    = 0;
        strobe_cnt = 0;
        valid_cnt  = 0;
        key_down   = 1'b0;
        key_row    = 2'd0;
        key_mask   = 4'h0;
        reset1     = 1'b1;

        // Reset values.
        tick();
        tick();
        check("rst_row_n",       32'(row_n),       32'hE);
        check("rst_entry_val",   32'(entry_val),   32'd0);
        check("rst_value",       32'(value),       32'd0);
        check("rst_value_valid", 32'(value_valid), 32'd0);
        check("rst_key_strobe",  32'(key_strobe),  32'd0);
        check("rst_key_code",    32'(key_code),    32'd0);
        check("rst_digit_count", 32'(digit_count), 32'd0);

        // Idle scan: row advances every 4 cycles.
        reset1 = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check("idle_row_n", 32'(row_n), 32'(rows[(k / 4) % 4]));
        end
        check("idle_strobes", 32'(strobe_cnt), 32'd0);
        check("idle_entry",   32'(entry_val),  32'd0);

        // 1, 2, 3, # commits 123.
        s0 = strobe_cnt;
        v0 = valid_cnt;
        press_key("k1", 2'd0, 4'b0001);
        check("e1", 32'(entry_val), 32'd1);
        check("code1", 32'(key_code), 32'd0);
        press_key("k2", 2'd0, 4'b0010);
        check("e12", 32'(entry_val), 32'd12);
        press_key("k3", 2'd0, 4'b0100);
        check("e123", 32'(entry_val), 32'd123);
        check("dc3", 32'(digit_count), 32'd3);
        check("val_before_hash", 32'(value), 32'd0);
        press_key("khash", 2'd3, 4'b0100);
        check("value123",   32'(value),          32'd123);
        check("code_hash",  32'(key_code),       32'd14);
        check("entry_clr",  32'(entry_val),      32'd0);
        check("dc_clr",     32'(digit_count),    32'd0);
        check("strobes4",   32'(strobe_cnt - s0), 32'd4);
        check("valid1",     32'(valid_cnt - v0),  32'd1);

        // Reset while '5' is held; key must fully re-debounce afterwards.
        press_key("k5_pre", 2'd1, 4'b0010);
        key_row  = 2'd1;
        key_mask = 4'b0010;
        key_down = 1'b1;
        seen     = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            tick();
            if (key_strobe === 1'b1) seen = 1'b1;
        end
        check("held_strobe", 32'(seen), 32'd1);
        tick();
        check("held_entry55", 32'(entry_val), 32'd55);
        reset1 = 1'b1;
        #1;
        check("mid_rst_row_n", 32'(row_n),       32'hE);
        check("mid_rst_entry", 32'(entry_val),   32'd0);
        check("mid_rst_value", 32'(value),       32'd0);
        check("mid_rst_dc",    32'(digit_count), 32'd0);
        check("mid_rst_code",  32'(key_code),    32'd0);
        check("mid_rst_strb",  32'(key_strobe),  32'd0);
        tick();
        reset1 = 1'b0;
        n_seen = 0;
        for (int n = 1; n <= 64 && n_seen == 0; n++) begin
            tick();
            if (key_strobe === 1'b1) n_seen = n;
        end
        check("rst_redebounce_cycle", 32'(n_seen), 32'd9);
        check("rst_redebounce_entry", 32'(entry_val), 32'd5);
        repeat (3) tick();
        key_down = 1'b0;
        repeat (12) tick();
        press_key("kstar1", 2'd3, 4'b0001);
        check("star_clr", 32'(entry_val), 32'd0);

        // Bounce on '5' while its row is driven, then stable.
        wait_row(4'b1101, 1'b0);
        wait_row(4'b1101, 1'b1);
        s0 = strobe_cnt;
        key_row  = 2'd1;
        key_mask = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            key_down = ((i / 2) % 2) == 0;
            tick();
        end
        check("bounce_no_strobe", 32'(strobe_cnt - s0), 32'd0);
        press_key("k5_stable", 2'd1, 4'b0010);
        check("bounce_one_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("bounce_entry5", 32'(entry_val), 32'd5);

        // Digit limit: 9, 9, 9, 7 stays at 999.
        press_key("kstar2", 2'd3, 4'b0001);
        s0 = strobe_cnt;
        press_key("k9a", 2'd2, 4'b0100);
        press_key("k9b", 2'd2, 4'b0100);
        press_key("k9c", 2'd2, 4'b0100);
        press_key("k7",  2'd2, 4'b0001);
        check("lim_entry999", 32'(entry_val),        32'd999);
        check("lim_dc3",      32'(digit_count),      32'd3);
        check("lim_strobes4", 32'(strobe_cnt - s0),  32'd4);
        check("lim_code7",    32'(key_code),         32'd8);
        check("lim_value",    32'(value),            32'd0);

        // 4 (two columns pressed), 2, A, # commits -42 or 42.
        press_key("kstar3", 2'd3, 4'b0001);
        press_key("k4multi", 2'd1, 4'b0101);
        check("multi_code4",  32'(key_code),  32'd4);
        check("multi_entry4", 32'(entry_val), 32'd4);
        press_key("k2b", 2'd0, 4'b0010);
        press_key("kA",  2'd0, 4'b1000);
        check("codeA", 32'(key_code), 32'd3);
`ifdef KEYPAD_NEG_EN
        check("neg_entry", 32'(entry_val), 32'h7FFD6);
`else
        check("neg_entry", 32'(entry_val), 32'd42);
`endif
        v0 = valid_cnt;
        press_key("khash2", 2'd3, 4'b0100);
`ifdef KEYPAD_NEG_EN
        check("neg_value", 32'(value), 32'h7FFD6);
`else
        check("neg_value", 32'(value), 32'd42);
`endif
        check("neg_valid1",   32'(valid_cnt - v0), 32'd1);
        check("neg_entry_clr", 32'(entry_val),     32'd0);
        check("final_valid_low", 32'(value_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
